// File: rtl/snap_vacc_ctrl_seq_pkg.sv
// Shared types and field positions for the snapshot/vector-accumulator sequencer.
package snap_vacc_ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_ALIGN   = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam int ARM_BIT   = 0;
    localparam int TRIG_BIT  = 1;
    localparam int SYNC_BIT  = 2;
    localparam int ABORT_BIT = 3;
    localparam int LEN_LSB   = 16;

    localparam int ST_FRAME_LSB    = 16;
    localparam int ST_TIMEOUT_BIT  = 7;
    localparam int ST_OVERFLOW_BIT = 6;
    localparam int ST_STATE_LSB    = 0;

    function automatic logic [31:0] pack_status(input logic [15:0] frame_cnt,
                                                input logic        timeout,
                                                input logic        overflow,
                                                input state_e      st);
        logic [31:0] w;
        w = '0;
        w[ST_FRAME_LSB +: 16]  = frame_cnt;
        w[ST_TIMEOUT_BIT]      = timeout;
        w[ST_OVERFLOW_BIT]     = overflow;
        w[ST_STATE_LSB +: 3]   = st;
        return w;
    endfunction

endpackage

// File: rtl/snap_vacc_ctrl_seq_if.sv
// Control, stream and result signals of the sequencer; slave = sequencer side.
interface snap_vacc_ctrl_seq_if #(
    parameter int ADDR_W = 10
);
    import snap_vacc_ctrl_seq_pkg::*;

    // Stream protocol: in_valid marks a beat and there is no ready; the sequencer
    // never stalls, so every valid beat is consumed in the cycle it is presented.
    // in_last is meaningful only together with in_valid.
    logic [31:0]       ctrl_word;
    logic              sync_in;
    logic              in_valid;
    logic              in_last;
    logic              acc_en;
    logic              acc_first;
    logic              snap_we;
    logic [ADDR_W-1:0] snap_addr;
    logic              busy;
    logic              done;
    logic [31:0]       status_word;
    state_e            dbg_state;

    modport slave (
        input  ctrl_word, sync_in, in_valid, in_last,
        output acc_en, acc_first, snap_we, snap_addr, busy, done, status_word, dbg_state
    );

    modport master (
        output ctrl_word, sync_in, in_valid, in_last,
        input  acc_en, acc_first, snap_we, snap_addr, busy, done, status_word, dbg_state
    );

endinterface

// File: rtl/snap_vacc_ctrl_edge.sv
// Registered rising-edge detector for one software control bit.
module snap_vacc_ctrl_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    // History resets low, so a bit held high through reset yields one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/snap_vacc_ctrl_seq.sv
// Snapshot/vector-accumulator sequencer: arm, trigger, N accumulation frames, one dump frame.
// Optional ARMED/ALIGN watchdog is built when SNAP_VACC_TIMEOUT_EN is defined.
module snap_vacc_ctrl_seq
    import snap_vacc_ctrl_seq_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 2**24
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    snap_vacc_ctrl_seq_if.slave  bus
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [15:0]        frame_cnt;
    logic [15:0]        len_ext;
    logic [ADDR_W-1:0]  snap_addr_q;
    logic               overflow_q, timeout_q;
    logic [31:0]        status_q;

    logic               arm_rise, trig_rise;
    logic               use_sync, abort;
    logic [LEN_W-1:0]   acc_len;
    logic               load_arm, frame_inc, addr_inc, set_ovf, set_to, to_hit;
    logic               acc_en, acc_first, snap_we, busy, done;
    logic               unused_ctrl;

    assign use_sync    = bus.ctrl_word[SYNC_BIT];
    assign abort       = bus.ctrl_word[ABORT_BIT];
    assign acc_len     = bus.ctrl_word[LEN_LSB +: LEN_W];
    assign unused_ctrl = ^bus.ctrl_word[LEN_LSB-1:ABORT_BIT+1];
    assign len_ext     = 16'(len_q);

    snap_vacc_ctrl_edge u_arm_edge (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .d     (bus.ctrl_word[ARM_BIT]),
        .rise  (arm_rise)
    );

    snap_vacc_ctrl_edge u_trig_edge (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .d     (bus.ctrl_word[TRIG_BIT]),
        .rise  (trig_rise)
    );

`ifdef SNAP_VACC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    // Counts cycles spent waiting for the trigger or frame boundary; ARMED->ALIGN does not restart it.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)                                  to_cnt <= '0;
        else if (state_q == ST_ARMED || state_q == ST_ALIGN) to_cnt <= to_cnt + 1'b1;
        else                                              to_cnt <= '0;
    end

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        load_arm  = 1'b0;
        frame_inc = 1'b0;
        addr_inc  = 1'b0;
        set_ovf   = 1'b0;
        set_to    = 1'b0;
        acc_en    = 1'b0;
        acc_first = 1'b0;
        snap_we   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_d  = ST_ARMED;
                    load_arm = 1'b1;
                end
            end
            ST_ARMED: begin
                busy = 1'b1;
                if (use_sync && bus.sync_in) state_d = ST_ACCUM;
                else if (trig_rise)          state_d = ST_ALIGN;
                if (to_hit) begin
                    state_d = ST_IDLE;
                    set_to  = 1'b1;
                end
            end
            ST_ALIGN: begin
                busy = 1'b1;
                if (bus.in_valid && bus.in_last) state_d = ST_ACCUM;
                if (to_hit) begin
                    state_d = ST_IDLE;
                    set_to  = 1'b1;
                end
            end
            ST_ACCUM: begin
                busy      = 1'b1;
                acc_en    = 1'b1;
                acc_first = (frame_cnt == 16'd0);
                if (bus.in_valid && bus.in_last) begin
                    frame_inc = 1'b1;
                    if (frame_cnt == len_ext - 16'd1) state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                busy    = 1'b1;
                snap_we = bus.in_valid;
                if (bus.in_valid) begin
                    // The top address saturates: later beats overwrite it and flag overflow.
                    if (&snap_addr_q) set_ovf  = ~bus.in_last;
                    else              addr_inc = 1'b1;
                    if (bus.in_last)  state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (arm_rise) begin
                    state_d  = ST_ARMED;
                    load_arm = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d   = ST_IDLE;
            load_arm  = 1'b0;
            frame_inc = 1'b0;
            addr_inc  = 1'b0;
            set_ovf   = 1'b0;
            set_to    = 1'b0;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            frame_cnt   <= '0;
            snap_addr_q <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= pack_status(frame_cnt, timeout_q, overflow_q, state_q);
            if (abort || load_arm) begin
                frame_cnt   <= '0;
                snap_addr_q <= '0;
                overflow_q  <= 1'b0;
                timeout_q   <= 1'b0;
            end else begin
                if (frame_inc) frame_cnt   <= frame_cnt + 16'd1;
                if (addr_inc)  snap_addr_q <= snap_addr_q + 1'b1;
                if (set_ovf)   overflow_q  <= 1'b1;
                if (set_to)    timeout_q   <= 1'b1;
            end
            // A zero length still runs one accumulation frame.
            if (load_arm) len_q <= (acc_len == '0) ? LEN_W'(1) : acc_len;
        end
    end

    assign bus.acc_en      = acc_en;
    assign bus.acc_first   = acc_first;
    assign bus.snap_we     = snap_we;
    assign bus.snap_addr   = snap_addr_q;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.status_word = status_q;
    assign bus.dbg_state   = state_q;

endmodule
